// File: rtl/pdm_pkg.sv
// pdm_pkg: shared state encoding, widths and gain saturation for pdm_mic_ctrl.
package pdm_pkg;
  localparam int PCM_W = 16;
  localparam int OVR_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, WAKEUP = 2'd1, DISCARD = 2'd2, RUN = 2'd3} state_t;
  function automatic logic [PCM_W-1:0] sat_shl(input logic [PCM_W-1:0] x, input logic [2:0] s);
    logic signed [PCM_W+7:0] w;
    w = $signed({{8{x[PCM_W-1]}}, x}) <<< s;
    return w > 32767 ? 16'h7fff : w < -32768 ? 16'h8000 : w[PCM_W-1:0];
  endfunction
endpackage

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen: PDM clock divider with strobes flagging the coming rise/fall.
module pdm_clk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic pdm_clk,
  output logic rise_next,
  output logic fall_next
);
  logic [7:0] div;
  logic tc;
  assign tc = div == 8'(CLK_DIV - 1);
  assign rise_next = run && tc && !pdm_clk;
  assign fall_next = run && tc && pdm_clk;
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div <= tc ? '0 : div + 8'd1;
      pdm_clk <= pdm_clk ^ tc;
    end
  end
endmodule

// File: rtl/pdm_mic_ctrl.sv
// pdm_mic_ctrl: PDM mic sequencer (clock, wakeup wait, settling discard, PCM valid/ready return).
// Define PDM_GAIN_EN for the saturating gain stage (adds gain port and one cycle of latency).
module pdm_mic_ctrl import pdm_pkg::*; #(
  parameter int CLK_DIV = 25,
  parameter int WAKE_CYCLES = 4096,
  parameter int DISCARD_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic pdm_clk_out,
  input  logic pdm_data_in,
  output logic pdm_bit,
  input  logic dec_pcm_clk,
  input  logic [PCM_W-1:0] dec_pcm,
  output logic [PCM_W-1:0] sample_data,
  output logic sample_valid,
  input  logic sample_ready,
  output logic running,
  output logic [OVR_W-1:0] overrun_count
`ifdef PDM_GAIN_EN
  , input logic [2:0] gain
`endif
);
  state_t state, state_next;
  logic rise_next, fall_next, s1, s2, s3, pcm_edge, pe, wake_done, disc_done;
  logic [15:0] wake_cnt;
  logic [7:0] disc_cnt;
  logic [PCM_W-1:0] pw;
  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk(clk),
    .reset(reset),
    .run(state != IDLE && enable),
    .pdm_clk(pdm_clk_out),
    .rise_next(rise_next),
    .fall_next(fall_next)
  );
  // dec_pcm is quasi-static by the time its clock edge is seen, so only the clock is synchronised
  assign pcm_edge = s2 && !s3;
`ifdef PDM_GAIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pe <= 1'b0;
      pw <= '0;
    end else begin
      pe <= pcm_edge;
      pw <= sat_shl(dec_pcm, gain);
    end
  end
`else
  assign pe = pcm_edge;
  assign pw = dec_pcm;
`endif
  assign wake_done = rise_next && wake_cnt == 16'(WAKE_CYCLES - 1);
  assign disc_done = pe && disc_cnt == 8'(DISCARD_SAMPLES - 1);
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = WAKEUP;
      WAKEUP:  if (wake_done) state_next = DISCARD_SAMPLES == 0 ? RUN : DISCARD;
      DISCARD: if (disc_done) state_next = RUN;
      default: ;
    endcase
    if (!enable) state_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {s3, s2, s1} <= '0;
      wake_cnt <= '0;
      disc_cnt <= '0;
      pdm_bit <= 1'b0;
      sample_data <= '0;
      sample_valid <= 1'b0;
      running <= 1'b0;
      overrun_count <= '0;
    end else begin
      state <= state_next;
      {s3, s2, s1} <= {s2, s1, dec_pcm_clk};
      running <= state == RUN;
      wake_cnt <= state != WAKEUP ? '0 : wake_cnt + 16'(rise_next);
      disc_cnt <= state != DISCARD ? '0 : disc_cnt + 8'(pe);
      if (fall_next) pdm_bit <= pdm_data_in;
      if (state != RUN || !enable) sample_valid <= 1'b0;
      else if (pe && (!sample_valid || sample_ready)) begin
        sample_data <= pw;
        sample_valid <= 1'b1;
      end else if (pe) overrun_count <= overrun_count + 8'(overrun_count != '1);
      else if (sample_ready) sample_valid <= 1'b0;
    end
  end
endmodule
